// File: rtl/reg_dump_uart.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_uart
// Purpose  : Snapshots eight 16-bit registers on request and streams them out
//            as one 8N1 UART frame (0xA5 header, rg0 hi/lo .. rg7 hi/lo).
//            Optional trailing checksum byte: define REG_DUMP_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] rg0,
    input  logic [15:0] rg1,
    input  logic [15:0] rg2,
    input  logic [15:0] rg3,
    input  logic [15:0] rg4,
    input  logic [15:0] rg5,
    input  logic [15:0] rg6,
    input  logic [15:0] rg7,
    input  logic        start,
    output logic        tx,
    output logic        busy,
    output logic        done
);

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int c_NUM_BYTES = 18;
`else
    localparam int c_NUM_BYTES = 17;
`endif
    localparam logic [4:0]  c_LAST_BYTE = 5'(c_NUM_BYTES - 1);
    localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  c_HEADER    = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [4:0]     byte_idx_q, byte_idx_d;
    logic [127:0]   snap_q, snap_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           bit_end;
    logic [7:0]     data_bytes [16];
    logic [7:0]     tx_byte;

    assign bit_end = (bit_cnt_q == c_BIT_LAST);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        snap_d     = snap_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d     = {rg0, rg1, rg2, rg3, rg4, rg5, rg6, rg7};
                    state_d    = START;
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (byte_idx_q == c_LAST_BYTE) begin
                        byte_idx_d = '0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 5'd1;
                        state_d    = START;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte 0 of the snapshot is rg0 high byte, byte 15 is rg7 low byte.
    always_comb begin
        for (int j = 0; j < 16; j++) begin
            data_bytes[j] = snap_q[8*(15-j) +: 8];
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = '0;
        for (int j = 0; j < 16; j++) begin
            checksum = checksum + data_bytes[j];
        end
    end
`endif

    // Output bit is derived from next-state values so tx/busy are registered
    // yet still change on the edge that moves the FSM.
    always_comb begin
        tx_byte = c_HEADER;
        if (byte_idx_d != 5'd0) begin
            tx_byte = data_bytes[4'(byte_idx_d - 5'd1)];
        end
`ifdef REG_DUMP_CHECKSUM_EN
        if (byte_idx_d == 5'd17) begin
            tx_byte = checksum;
        end
`endif
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = tx_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            snap_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            snap_q     <= snap_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_dump_uart
// Purpose  : Directed self-checking bench for reg_dump_uart at CLKS_PER_BIT=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_uart;

    localparam int CPB = 4;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int NB       = 18;
    localparam int DONE_CYC = 721;
`else
    localparam int NB       = 17;
    localparam int DONE_CYC = 681;
`endif
    localparam int FRAME = NB * 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] rg [8];
    logic        tx, busy, done;

    int total  = 0;
    int passed = 0;

    logic        tx_s   [0:1023];
    logic        busy_s [0:1023];
    logic        done_s [0:1023];
    logic [15:0] snap   [8];

    always #5 clk = ~clk;

    reg_dump_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .reset(reset),
        .rg0  (rg[0]),
        .rg1  (rg[1]),
        .rg2  (rg[2]),
        .rg3  (rg[3]),
        .rg4  (rg[4]),
        .rg5  (rg[5]),
        .rg6  (rg[6]),
        .rg7  (rg[7]),
        .start(start),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    // Pulses start for one edge (cycle 0), then records outputs for cycles
    // 1..ncyc. act_kind at act_cyc: 1 = rg3<=AAAA, 2 = start pulse, 3 = reset pulse.
    task automatic capture(input int ncyc, input int act_cyc, input int act_kind);
        snap = rg;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (k == act_cyc) begin
                case (act_kind)
                    1: rg[3] = 16'hAAAA;
                    2: start = 1'b1;
                    3: reset = 1'b1;
                    default: ;
                endcase
            end
            if (k == act_cyc + 1) begin
                start = 1'b0;
                reset = 1'b0;
            end
            tx_s[k]   = tx;
            busy_s[k] = busy;
            done_s[k] = done;
            @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    function automatic logic [7:0] dec(input int i);
        logic [7:0] d;
        for (int b = 0; b < 8; b++) d[b] = tx_s[i*10*CPB + (b+1)*CPB + CPB/2];
        return d;
    endfunction

    function automatic int framing_errs(input int nbytes);
        int e = 0;
        for (int i = 0; i < nbytes; i++) begin
            if (tx_s[i*10*CPB + CPB/2] !== 1'b0) e++;
            if (tx_s[i*10*CPB + 9*CPB + CPB/2] !== 1'b1) e++;
        end
        return e;
    endfunction

    function automatic logic [7:0] model(input int i);
        logic [15:0] r;
        logic [7:0]  s = 8'h00;
        if (i == 0) return 8'hA5;
        if (i == 17) begin
            for (int j = 0; j < 8; j++) s = s + snap[j][15:8] + snap[j][7:0];
            return s;
        end
        r = snap[(i-1)/2];
        return ((i-1) % 2 == 0) ? r[15:8] : r[7:0];
    endfunction

    function automatic int first_done(input int ncyc);
        for (int k = 1; k <= ncyc; k++) if (done_s[k] === 1'b1) return k;
        return -1;
    endfunction

    function automatic int done_count(input int ncyc);
        int c = 0;
        for (int k = 1; k <= ncyc; k++) if (done_s[k] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (tx !== 1'b1) $display("FAIL reset_tx got=%b exp=1", tx); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp_tab [17] = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBE, 8'hEF};
        int bad_busy = 0;
        for (int j = 0; j < 8; j++) rg[j] = 16'h0000;
        rg[0] = 16'h1234;
        rg[7] = 16'hBEEF;
        capture(FRAME + 8, 0, 0);
        total++; if (tx_s[1] !== 1'b0) $display("FAIL basic_first_start_bit got=%b exp=0", tx_s[1]); else passed++;
        for (int i = 0; i < 17; i++) begin
            total++;
            if (dec(i) !== exp_tab[i]) $display("FAIL basic_byte%0d got=%h exp=%h", i, dec(i), exp_tab[i]);
            else passed++;
        end
        total++; if (framing_errs(NB) != 0) $display("FAIL basic_framing got=%0d errors exp=0", framing_errs(NB)); else passed++;
        for (int k = 1; k <= FRAME; k++) if (busy_s[k] !== 1'b1) bad_busy++;
        total++; if (bad_busy != 0) $display("FAIL basic_busy_low_cycles got=%0d exp=0", bad_busy); else passed++;
        total++; if (first_done(FRAME + 8) != DONE_CYC) $display("FAIL basic_done_cycle got=%0d exp=%0d", first_done(FRAME + 8), DONE_CYC); else passed++;
        total++; if (done_count(FRAME + 8) != 1) $display("FAIL basic_done_pulses got=%0d exp=1", done_count(FRAME + 8)); else passed++;
        total++; if (busy_s[DONE_CYC] !== 1'b0) $display("FAIL basic_busy_at_done got=%b exp=0", busy_s[DONE_CYC]); else passed++;
    endtask

    task automatic test_snapshot();
        for (int j = 0; j < 8; j++) rg[j] = 16'h0000;
        rg[3] = 16'h00FF;
        capture(FRAME + 4, 5, 1);
        total++; if (dec(7) !== 8'h00) $display("FAIL snapshot_rg3_hi got=%h exp=00", dec(7)); else passed++;
        total++; if (dec(8) !== 8'hFF) $display("FAIL snapshot_rg3_lo got=%h exp=ff", dec(8)); else passed++;
        rg[3] = 16'h0000;
    endtask

    task automatic test_start_ignored();
        int idle_bad = 0;
        for (int j = 0; j < 8; j++) rg[j] = 16'h0F0F + 16'(j);
        capture(FRAME + 60, 100, 2);
        total++; if (done_count(FRAME + 60) != 1) $display("FAIL ignore_done_pulses got=%0d exp=1", done_count(FRAME + 60)); else passed++;
        total++; if (first_done(FRAME + 60) != DONE_CYC) $display("FAIL ignore_done_cycle got=%0d exp=%0d", first_done(FRAME + 60), DONE_CYC); else passed++;
        for (int k = DONE_CYC; k <= FRAME + 60; k++) if (tx_s[k] !== 1'b1 || busy_s[k] !== 1'b0) idle_bad++;
        total++; if (idle_bad != 0) $display("FAIL ignore_idle_after got=%0d bad cycles exp=0", idle_bad); else passed++;
        total++; if (dec(16) !== model(16)) $display("FAIL ignore_last_byte got=%h exp=%h", dec(16), model(16)); else passed++;
    endtask

    task automatic test_midframe_reset();
        int idle_bad = 0;
        int byte_bad = 0;
        capture(260, 200, 3);
        total++; if (tx_s[201] !== 1'b1) $display("FAIL midreset_tx got=%b exp=1", tx_s[201]); else passed++;
        total++; if (busy_s[201] !== 1'b0) $display("FAIL midreset_busy got=%b exp=0", busy_s[201]); else passed++;
        total++; if (done_count(260) != 0) $display("FAIL midreset_done_pulses got=%0d exp=0", done_count(260)); else passed++;
        for (int k = 201; k <= 260; k++) if (tx_s[k] !== 1'b1) idle_bad++;
        total++; if (idle_bad != 0) $display("FAIL midreset_tx_idle got=%0d bad cycles exp=1s", idle_bad); else passed++;
        for (int j = 0; j < 8; j++) rg[j] = 16'h1111 * 16'(j) + 16'h0102;
        capture(FRAME + 4, 0, 0);
        for (int i = 0; i < NB; i++) if (dec(i) !== model(i)) byte_bad++;
        total++; if (byte_bad != 0) $display("FAIL midreset_new_frame got=%0d bad bytes exp=0", byte_bad); else passed++;
        total++; if (framing_errs(NB) != 0) $display("FAIL midreset_framing got=%0d errors exp=0", framing_errs(NB)); else passed++;
        total++; if (first_done(FRAME + 4) != DONE_CYC) $display("FAIL midreset_done_cycle got=%0d exp=%0d", first_done(FRAME + 4), DONE_CYC); else passed++;
    endtask

    task automatic test_back_to_back();
        capture(FRAME + 3, FRAME + 1, 2);
        total++; if (done_s[FRAME + 1] !== 1'b1) $display("FAIL b2b_done got=%b exp=1", done_s[FRAME + 1]); else passed++;
        total++; if (busy_s[FRAME + 2] !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", busy_s[FRAME + 2]); else passed++;
        total++; if (tx_s[FRAME + 2] !== 1'b0) $display("FAIL b2b_start_bit got=%b exp=0", tx_s[FRAME + 2]); else passed++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

`ifdef REG_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        for (int j = 0; j < 8; j++) rg[j] = 16'h0101;
        capture(FRAME + 4, 0, 0);
        total++; if (dec(17) !== 8'h10) $display("FAIL checksum_byte got=%h exp=10", dec(17)); else passed++;
        total++; if (first_done(FRAME + 4) != 721) $display("FAIL checksum_done_cycle got=%0d exp=721", first_done(FRAME + 4)); else passed++;
    endtask
`endif

    initial begin
        for (int j = 0; j < 8; j++) rg[j] = 16'h0000;
        test_reset();
        test_basic_frame();
        test_snapshot();
        test_start_ignored();
        test_midframe_reset();
        test_back_to_back();
`ifdef REG_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_dump_uart.md
REG_DUMP_UART -- requirements
Module: reg_dump_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports rg0..rg7, input, 16 each, register-file values from the processor core.
REQ-005 SHALL have port start, input, 1, dump request; sampled each rising edge.
REQ-006 SHALL have port tx, output, 1, UART serial line, idle high.
REQ-007 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse at frame completion.

Function
REQ-009 SHALL accept start only in IDLE; start while busy=1 is ignored, never queued.
REQ-010 SHALL, on the edge accepting start, snapshot rg0..rg7 into an internal 128-bit buffer; input changes after that edge SHALL NOT affect the frame.
REQ-011 SHALL set busy=1 and drive tx=0 (first start bit) from the cycle after the accepting edge.
REQ-012 SHALL send the frame as: header byte 0xA5, then rg0 high byte, rg0 low byte, rg1 high, ... rg7 low (17 bytes).
REQ-013 SHALL send each byte as 8N1: start bit 0, data bits LSB first, one stop bit 1; each bit held exactly CLKS_PER_BIT cycles; no idle gap between bytes.
REQ-014 SHALL use FSM states IDLE, START, DATA, STOP; IDLE->START on accepted start; START->DATA after one bit time; DATA->STOP after 8 bit times; STOP->START if bytes remain, else STOP->IDLE.
REQ-015 SHALL use a bit-time counter counting 0..CLKS_PER_BIT-1 and wrapping to 0, a 3-bit data-bit index, and a 5-bit byte index.
REQ-016 SHALL, on the STOP->IDLE transition, pulse done=1 for exactly one cycle and drop busy to 0 in that same cycle.
REQ-017 SHALL therefore, with the accepting edge at cycle 0, hold busy high for cycles 1..N*10*CLKS_PER_BIT and pulse done at cycle N*10*CLKS_PER_BIT+1, N = frame byte count.
REQ-018 SHALL keep tx=1 at all times in IDLE.
REQ-019 SHALL accept a start asserted in the same cycle done pulses only from the following cycle (start in the done cycle is accepted, since state is IDLE).

Reset
REQ-020 SHALL, when reset=1 on a rising edge, force state IDLE, tx=1, busy=0, done=0, all counters 0, regardless of frame progress.
REQ-021 SHALL give reset priority over start in the same cycle; the interrupted frame is abandoned and not resumed.

Configuration
REQ-022 SHALL, when macro REG_DUMP_CHECKSUM_EN is defined, append one checksum byte after rg7 low byte: 8-bit modulo-256 sum of the 16 data bytes (header excluded); N=18.
REQ-023 SHALL, when REG_DUMP_CHECKSUM_EN is undefined, send no checksum byte; N=17; no checksum logic present.

Verification (CLKS_PER_BIT=4)
REQ-024 SHALL verify reset: reset held 2 cycles -> tx=1, busy=0, done=0 on following cycle; start then accepted normally.
REQ-025 SHALL verify basic frame: rg0=0x1234, rg7=0xBEEF, others 0, start 1 cycle -> decoded bytes A5,12,34,00x12,BE,EF; done at cycle 681 (no macro).
REQ-026 SHALL verify snapshot: start with rg3=0x00FF, set rg3=0xAAAA on cycle 5 -> bytes 7,8 decode 00,FF.
REQ-027 SHALL verify start ignored while busy: second start at cycle 100 -> exactly one frame, single done pulse, tx idle after.
REQ-028 SHALL verify reset mid-frame: reset at cycle 200 -> tx=1, busy=0 next cycle; no done pulse; new start yields a complete, correct frame.
REQ-029 SHALL verify checksum with REG_DUMP_CHECKSUM_EN: all rgN=0x0101 -> 18th byte 0x10; done at cycle 721.
